// File: rtl/tape_load_ctrl_pkg.sv
// Shared types and constants for the tape quick-load controller.
package tape_load_pkg;

   typedef enum logic [1:0] {IDLE, READY, COPY, DONE} state_t;

   localparam logic [7:0] XOR_A = 8'hAF;
   localparam logic [7:0] NOP   = 8'h00;
   localparam logic [7:0] SCF   = 8'h37;
   localparam logic [7:0] JR_NC = 8'h30;
   localparam logic [7:0] OFS   = 8'hFD;
   localparam logic [7:0] JP    = 8'hC3;
   localparam logic [7:0] JP_HI = 8'h02;

   localparam logic [7:0] RET_LO_ZX81 = 8'h07;
   localparam logic [7:0] RET_LO_ZX80 = 8'h03;

   localparam logic [15:0] BASE_O = 16'h4000;
   localparam logic [15:0] BASE_P = 16'h4009;

endpackage

// File: rtl/tape_load_ctrl_patch_rom.sv
// Seven-byte LOAD patch loop; bytes 1 and 5 are rewritten while the load runs.
module tape_patch_rom
   import tape_load_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        set_entry,
   input  logic        set_done,
   input  logic        zx81,
   input  logic [15:0] offset,
   output logic [7:0]  dout
);

   logic [7:0] patch1;
   logic [7:0] patch5;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         patch1 <= NOP;
         patch5 <= '0;
      end else if (set_entry) begin
         patch1 <= NOP;
         patch5 <= zx81 ? RET_LO_ZX81 : RET_LO_ZX80;
      end else if (set_done) begin
         patch1 <= SCF;
      end
   end

   always_comb begin
      dout = 8'hFF;
      case (offset)
         16'd0:   dout = XOR_A;
         16'd1:   dout = patch1;
         16'd2:   dout = JR_NC;
         16'd3:   dout = OFS;
         16'd4:   dout = JP;
         16'd5:   dout = patch5;
         16'd6:   dout = JP_HI;
         default: dout = 8'hFF;
      endcase
   end

endmodule

// File: rtl/tape_load_ctrl.sv
// Tape quick-load sequencer: traps ROM LOAD, copies the buffer to RAM, releases the CPU.
// Optional macro TAPE_LOAD_LED_EN adds a copy-progress LED.
module tape_load_ctrl
   import tape_load_pkg::*;
#(
   parameter int unsigned TAPE_AW    = 14,
   parameter logic [15:0] ZX81_ENTRY = 16'h0347,
   parameter logic [15:0] ZX81_EXIT  = 16'h03C3,
   parameter logic [15:0] ZX80_ENTRY = 16'h0207,
   parameter logic [15:0] ZX80_EXIT  = 16'h024D
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               ce_cpu_p,
   input  logic               zx81,
   input  logic               nM1,
   input  logic [15:0]        addr,
   input  logic               dl_active,
   input  logic               dl_is_tape,
   input  logic               dl_is_p,
   input  logic [TAPE_AW-1:0] tape_len,
   output logic [TAPE_AW-1:0] tape_rd_addr,
   input  logic [7:0]         tape_rd_data,
   output logic               ram_we,
   output logic [15:0]        ram_wr_addr,
   output logic [7:0]         ram_wr_data,
   output logic               active,
   output logic [7:0]         patch_dout,
   output logic               tape_ready,
   output logic               led
);

   state_t      state_q, state_n;
   logic        nm1_q, dl_q, ram_we_q;
   logic        m1_fall, dl_rise, dl_fall;
   logic        at_entry, at_exit;
   logic        start, step, finish;
   logic [15:0] entry_addr, exit_addr;
   logic [7:0]  rom_dout;

   assign m1_fall    = nm1_q & ~nM1;
   assign dl_rise    = dl_active & ~dl_q;
   assign dl_fall    = ~dl_active & dl_q;
   assign entry_addr = zx81 ? ZX81_ENTRY : ZX80_ENTRY;
   assign exit_addr  = zx81 ? ZX81_EXIT  : ZX80_EXIT;
   assign at_entry   = m1_fall && (addr == entry_addr);
   assign at_exit    = m1_fall && ((addr >= exit_addr) || (addr < entry_addr));

   always_comb begin
      state_n = state_q;
      start   = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      if (dl_rise) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE:  if (tape_ready) state_n = READY;
            READY: if (at_entry) begin
                      state_n = COPY;
                      start   = 1'b1;
                   end
            COPY:  if (at_exit) begin
                      state_n = READY;
                   end else if (ce_cpu_p) begin
                      if (tape_rd_addr != tape_len) begin
                         step = 1'b1;
                      end else begin
                         finish  = 1'b1;
                         state_n = DONE;
                      end
                   end
            DONE:  if (at_exit) state_n = READY;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         nm1_q        <= 1'b1;
         dl_q         <= 1'b0;
         tape_ready   <= 1'b0;
         tape_rd_addr <= '0;
         ram_we_q     <= 1'b0;
         ram_wr_addr  <= '0;
         ram_wr_data  <= '0;
      end else begin
         state_q  <= state_n;
         nm1_q    <= nM1;
         dl_q     <= dl_active;
         ram_we_q <= step;
         if (dl_rise)
            tape_ready <= 1'b0;
         else if (dl_fall && dl_is_tape)
            tape_ready <= 1'b1;
         if (start)
            tape_rd_addr <= '0;
         else if (step) begin
            ram_wr_data  <= tape_rd_data;
            ram_wr_addr  <= (dl_is_p ? BASE_P : BASE_O) + 16'(tape_rd_addr);
            tape_rd_addr <= tape_rd_addr + 1'b1;
         end
      end
   end

   // A strobe already queued from the last step is dropped if a download starts now.
   assign ram_we = ram_we_q && (state_q == COPY) && !reset && !dl_rise;
   assign active = (state_q == COPY) || (state_q == DONE);

   tape_patch_rom u_patch (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .set_entry (start),
      .set_done  (finish),
      .zx81      (zx81),
      .offset    (addr - entry_addr),
      .dout      (rom_dout)
   );

   assign patch_dout = active ? rom_dout : '0;

`ifdef TAPE_LOAD_LED_EN
   logic led_q;

   always_ff @(posedge clk_sys) begin
      if (reset)
         led_q <= 1'b0;
      else if (start)
         led_q <= 1'b1;
      else if (step && (tape_rd_addr[7:0] == 8'hFF))
         led_q <= ~led_q;
   end

   always_comb begin
      led = 1'b0;
      case (state_q)
         IDLE:    led = dl_active;
         READY:   led = 1'b1;
         COPY:    led = led_q;
         DONE:    led = 1'b1;
         default: led = 1'b0;
      endcase
   end
`else
   assign led = tape_ready | dl_active;
`endif

endmodule

// File: tb/tb_tape_load_ctrl.sv
// Directed self-checking bench for tape_load_ctrl.
module tb_tape_load_ctrl;

   localparam int unsigned TAPE_AW = 14;

   logic               clk_sys = 1'b0;
   logic               reset = 1'b1;
   logic               ce_cpu_p = 1'b0;
   logic               zx81 = 1'b1;
   logic               nM1 = 1'b1;
   logic [15:0]        addr = '0;
   logic               dl_active = 1'b0;
   logic               dl_is_tape = 1'b0;
   logic               dl_is_p = 1'b0;
   logic [TAPE_AW-1:0] tape_len = '0;
   logic [TAPE_AW-1:0] tape_rd_addr;
   logic [7:0]         tape_rd_data = '0;
   logic               ram_we;
   logic [15:0]        ram_wr_addr;
   logic [7:0]         ram_wr_data;
   logic               active;
   logic [7:0]         patch_dout;
   logic               tape_ready;
   logic               led;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:(1<<TAPE_AW)-1];
   logic [15:0] wr_a [0:15];
   logic [7:0]  wr_d [0:15];
   int          wr_n = 0;

   tape_load_ctrl #(.TAPE_AW(TAPE_AW)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_cpu_p     (ce_cpu_p),
      .zx81         (zx81),
      .nM1          (nM1),
      .addr         (addr),
      .dl_active    (dl_active),
      .dl_is_tape   (dl_is_tape),
      .dl_is_p      (dl_is_p),
      .tape_len     (tape_len),
      .tape_rd_addr (tape_rd_addr),
      .tape_rd_data (tape_rd_data),
      .ram_we       (ram_we),
      .ram_wr_addr  (ram_wr_addr),
      .ram_wr_data  (ram_wr_data),
      .active       (active),
      .patch_dout   (patch_dout),
      .tape_ready   (tape_ready),
      .led          (led)
   );

   always #5 clk_sys = ~clk_sys;

   initial for (int i = 0; i < (1 << TAPE_AW); i++) mem[i] = 8'((i * 7) + 3);

   always @(posedge clk_sys) tape_rd_data <= mem[tape_rd_addr];

   always @(posedge clk_sys) begin
      if (ram_we) begin
         if (wr_n < 16) begin
            wr_a[wr_n] = ram_wr_addr;
            wr_d[wr_n] = ram_wr_data;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic do_reset();
      dl_active = 1'b0; ce_cpu_p = 1'b0; nM1 = 1'b1; addr = '0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      wr_n = 0;
   endtask

   task automatic download(input logic is_p, input int len);
      dl_is_tape = 1'b1;
      dl_is_p    = is_p;
      tape_len   = TAPE_AW'(len);
      dl_active  = 1'b1;
      tick(3);
      dl_active  = 1'b0;
      tick(2);
   endtask

   task automatic m1(input logic [15:0] a);
      addr = a;
      nM1  = 1'b0;
      tick(1);
      nM1  = 1'b1;
      tick(1);
   endtask

   task automatic ce_pulses(input int n);
      repeat (n) begin
         ce_cpu_p = 1'b1;
         tick(1);
         ce_cpu_p = 1'b0;
         tick(3);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({active, ram_we, tape_ready, led} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {active, ram_we, tape_ready, led});
      end
      checks++;
      if (tape_rd_addr !== '0 || patch_dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_regs: rd_addr=%h patch=%h expected 0/00", tape_rd_addr, patch_dout);
      end
   endtask

   task automatic test_tape_ready();
      dl_is_tape = 1'b1;
      dl_active = 1'b1;
      tick(3);
      dl_active = 1'b0;
      tick(1);
      checks++;
      if (tape_ready !== 1'b1) begin
         errors++;
         $display("FAIL tape_ready_set: got %b expected 1", tape_ready);
      end
      do_reset();
      checks++;
      if (tape_ready !== 1'b0 || active !== 1'b0) begin
         errors++;
         $display("FAIL tape_ready_reset: ready=%b active=%b expected 0/0", tape_ready, active);
      end
   endtask

   task automatic test_zx81_o();
      do_reset();
      zx81 = 1'b1;
      download(1'b0, 3);
      m1(16'h0347);
      checks++;
      if (active !== 1'b1 || patch_dout !== 8'hAF) begin
         errors++;
         $display("FAIL zx81_entry: active=%b patch=%h expected 1/AF", active, patch_dout);
      end
      addr = 16'h034C; #1;
      checks++;
      if (patch_dout !== 8'h07) begin
         errors++;
         $display("FAIL zx81_patch5: got %h expected 07", patch_dout);
      end
      ce_pulses(4);
      checks++;
      if (wr_n !== 3) begin
         errors++;
         $display("FAIL zx81_wr_count: got %0d expected 3", wr_n);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_a[i] !== 16'h4000 + 16'(i) || wr_d[i] !== mem[i]) begin
            errors++;
            $display("FAIL zx81_wr%0d: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i],
                     16'h4000 + 16'(i), mem[i]);
         end
      end
      addr = 16'h0348; #1;
      checks++;
      if (patch_dout !== 8'h37 || tape_rd_addr !== 14'd3) begin
         errors++;
         $display("FAIL zx81_done: patch=%h rd_addr=%0d expected 37/3", patch_dout, tape_rd_addr);
      end
   endtask

   task automatic test_zx80_p();
      do_reset();
      zx81 = 1'b0;
      download(1'b1, 2);
      m1(16'h0207);
      addr = 16'h020C; #1;
      checks++;
      if (patch_dout !== 8'h03) begin
         errors++;
         $display("FAIL zx80_patch5: got %h expected 03", patch_dout);
      end
      ce_pulses(3);
      checks++;
      if (wr_n !== 2 || wr_a[0] !== 16'h4009 || wr_a[1] !== 16'h400A) begin
         errors++;
         $display("FAIL zx80_wr_addr: n=%0d a0=%h a1=%h expected 2/4009/400A", wr_n, wr_a[0], wr_a[1]);
      end
      checks++;
      if (wr_d[0] !== mem[0] || wr_d[1] !== mem[1]) begin
         errors++;
         $display("FAIL zx80_wr_data: got %h %h expected %h %h", wr_d[0], wr_d[1], mem[0], mem[1]);
      end
      addr = 16'h0208; #1;
      checks++;
      if (patch_dout !== 8'h37) begin
         errors++;
         $display("FAIL zx80_done: got %h expected 37", patch_dout);
      end
   endtask

   task automatic test_exit_reload();
      do_reset();
      zx81 = 1'b1;
      download(1'b0, 3);
      m1(16'h0347);
      ce_pulses(4);
      m1(16'h03C2);
      checks++;
      if (active !== 1'b1) begin
         errors++;
         $display("FAIL exit_below_bound: active=%b expected 1", active);
      end
      m1(16'h03C3);
      checks++;
      if (active !== 1'b0 || patch_dout !== 8'h00) begin
         errors++;
         $display("FAIL exit_at_bound: active=%b patch=%h expected 0/00", active, patch_dout);
      end
      wr_n = 0;
      m1(16'h0347);
      addr = 16'h0348; #1;
      checks++;
      if (active !== 1'b1 || tape_rd_addr !== '0 || patch_dout !== 8'h00) begin
         errors++;
         $display("FAIL reload: active=%b rd_addr=%0d patch=%h expected 1/0/00",
                  active, tape_rd_addr, patch_dout);
      end
      ce_pulses(1);
      checks++;
      if (wr_n !== 1 || wr_a[0] !== 16'h4000 || wr_d[0] !== mem[0]) begin
         errors++;
         $display("FAIL reload_write: n=%0d a=%h d=%h expected 1/4000/%h", wr_n, wr_a[0], wr_d[0], mem[0]);
      end
      ce_pulses(3);
      m1(16'h0346);
      checks++;
      if (active !== 1'b0) begin
         errors++;
         $display("FAIL exit_below_entry: active=%b expected 0", active);
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      zx81 = 1'b1;
      download(1'b0, 0);
      m1(16'h0347);
      ce_pulses(1);
      addr = 16'h0348; #1;
      checks++;
      if (wr_n !== 0 || patch_dout !== 8'h37 || active !== 1'b1) begin
         errors++;
         $display("FAIL zero_len: n=%0d patch=%h active=%b expected 0/37/1", wr_n, patch_dout, active);
      end
   endtask

   task automatic test_abort();
      do_reset();
      zx81 = 1'b1;
      download(1'b0, 10);
      m1(16'h0347);
      ce_pulses(2);
      ce_cpu_p = 1'b1;
      tick(1);
      ce_cpu_p = 1'b0;
      dl_active = 1'b1;
      #1;
      checks++;
      if (ram_we !== 1'b0) begin
         errors++;
         $display("FAIL abort_pending_we: got %b expected 0", ram_we);
      end
      tick(1);
      ce_pulses(3);
      checks++;
      if (wr_n !== 2) begin
         errors++;
         $display("FAIL abort_writes: got %0d expected 2", wr_n);
      end
      checks++;
      if (active !== 1'b0 || tape_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: active=%b ready=%b expected 0/0", active, tape_ready);
      end
      dl_active = 1'b0;
      tick(1);
   endtask

   task automatic test_led();
      do_reset();
      zx81 = 1'b1;
      download(1'b0, 600);
      checks++;
      if (led !== 1'b1) begin
         errors++;
         $display("FAIL led_ready: got %b expected 1", led);
      end
      m1(16'h0347);
`ifdef TAPE_LOAD_LED_EN
      ce_pulses(255);
      checks++;
      if (led !== 1'b1) begin
         errors++;
         $display("FAIL led_255: got %b expected 1", led);
      end
      ce_pulses(1);
      checks++;
      if (led !== 1'b0) begin
         errors++;
         $display("FAIL led_256: got %b expected 0", led);
      end
      ce_pulses(255);
      checks++;
      if (led !== 1'b0) begin
         errors++;
         $display("FAIL led_511: got %b expected 0", led);
      end
      ce_pulses(1);
      checks++;
      if (led !== 1'b1) begin
         errors++;
         $display("FAIL led_512: got %b expected 1", led);
      end
      ce_pulses(88);
      checks++;
      if (led !== 1'b1 || tape_rd_addr !== 14'd600) begin
         errors++;
         $display("FAIL led_done: led=%b rd_addr=%0d expected 1/600", led, tape_rd_addr);
      end
`else
      ce_pulses(300);
      checks++;
      if (led !== 1'b1) begin
         errors++;
         $display("FAIL led_copy: got %b expected 1", led);
      end
      do_reset();
      checks++;
      if (led !== 1'b0) begin
         errors++;
         $display("FAIL led_after_reset: got %b expected 0", led);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_tape_ready();
      test_zx81_o();
      test_zx80_p();
      test_exit_reload();
      test_zero_len();
      test_abort();
      test_led();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tape_load_ctrl.md
Name: tape_load_ctrl

Overview:
- Sequences quick-loading of a downloaded .o/.p image from tape buffer memory into main RAM.
- Detects the CPU's M1 fetch at the ROM LOAD entry and substitutes a 7-byte patch loop for the ROM bytes.
- Copies buffer bytes into RAM, paced by ce_cpu_p, then releases the CPU by making the patch return carry set.
- Sits between the HPS download path, the tape buffer RAM, the main RAM write port and the CPU data-in mux.

Parameters:
- TAPE_AW, 14, tape buffer address width (16 KB buffer).
- ZX81_ENTRY, 16'h0347, ZX81 LOAD patch entry address.
- ZX81_EXIT, 16'h03C3, ZX81 exit bound: an M1 at or above it leaves the patch.
- ZX80_ENTRY, 16'h0207, ZX80 LOAD patch entry address.
- ZX80_EXIT, 16'h024D, ZX80 exit bound.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_cpu_p  in  1  CPU positive clock enable
- zx81  in  1  1 = ZX81 model, 0 = ZX80
- nM1  in  1  CPU M1, active low
- addr  in  16  CPU address bus
- dl_active  in  1  HPS download in progress
- dl_is_tape  in  1  current download index is non-zero (tape image)
- dl_is_p  in  1  image is .p (index[7:6] != 0)
- tape_len  in  TAPE_AW  last written buffer address (ioctl_addr)
- tape_rd_addr  out  TAPE_AW  buffer read address
- tape_rd_data  in  8  buffer read data, valid 1 cycle after tape_rd_addr
- ram_we  out  1  one-cycle main RAM write strobe
- ram_wr_addr  out  16  CPU-space destination address
- ram_wr_data  out  8  byte to write
- active  out  1  patch overlay enabled; CPU memory reads take patch_dout
- patch_dout  out  8  combinational patch byte for the current addr
- tape_ready  out  1  tape image present
- led  out  1  status LED

Behaviour:
- Reset values: all outputs 0; state IDLE; tape_rd_addr 0.
- tape_ready is set on the falling edge of dl_active when dl_is_tape=1. It is cleared by reset, and by the rising edge of dl_active, which also forces IDLE from any state.
- ENTRY/EXIT are chosen by zx81. Events are sampled only on the nM1 falling edge (nM1 registered).
- States:
  - IDLE: wait for tape_ready → READY.
  - READY: on M1 at ENTRY: tape_rd_addr←0, patch[1]←8'h00, patch[5]←ZX81 ? 8'h07 : 8'h03, active←1 → COPY.
  - COPY: on each ce_cpu_p, if tape_rd_addr != tape_len:
    - ram_wr_data←tape_rd_data;
    - ram_wr_addr←(dl_is_p ? 16'h4009 : 16'h4000) + tape_rd_addr;
    - ram_we←1 for exactly the next clk_sys cycle;
    - tape_rd_addr++.
    - When tape_rd_addr == tape_len: patch[1]←8'h37 (scf) → DONE. The final byte at tape_len is not copied.
  - DONE: hold active.
  - COPY and DONE exit: on M1 with addr ≥ EXIT or addr < ENTRY: active←0 → READY. This allows a re-load.
- Entry takes priority over exit on the same M1.
- Patch image: AF, patch[1], 30, FD, C3, patch[5], 02.
  - patch_dout = patch[addr-ENTRY] for offsets 0..6; 8'hFF otherwise.
  - patch_dout is valid whenever active=1.
- tape_len = 0: COPY copies nothing; DONE follows on the first ce_cpu_p.
- tape_rd_addr wraps at 2^TAPE_AW; it never exceeds tape_len.
- ram_we never asserts outside COPY or during reset.
- Reset or download start mid-COPY:
  - abort immediately, no further writes;
  - a pending ram_we is suppressed;
  - active←0.

Optional Feature:
- Macro: TAPE_LOAD_LED_EN
- Defined: led = 1 in READY. In COPY, led toggles every 256 bytes copied (toggle when tape_rd_addr[7:0] wraps). In DONE, led = 1. In IDLE, led = dl_active.
- Not defined: led = tape_ready | dl_active. No progress counter logic is synthesized.

Decomposition:
- Package tape_load_pkg:
  - state enum {IDLE, READY, COPY, DONE};
  - patch byte constants (XOR_A 8'hAF, NOP 8'h00, SCF 8'h37, JR_NC 8'h30, OFS 8'hFD, JP 8'hC3);
  - load base constants 16'h4000 and 16'h4009.
- One sub-module, tape_patch_rom: 7-entry patch store with two writable bytes and offset decode to patch_dout.

Test Plan:
1. dl_active 1→0 with dl_is_tape=1 → tape_ready=1 next cycle; reset → tape_ready=0, active=0.
2. zx81=1, tape_len=3, .o image; M1 at 0x0347 → active=1, patch_dout=AF; four ce_cpu_p → exactly 3 writes to 0x4000, 0x4001, 0x4002 with buffer bytes 0..2, then M1 at 0x0348 reads 8'h37.
3. zx81=0, dl_is_p=1, tape_len=2; M1 at 0x0207 → writes to 0x4009 and 0x400A; patch_dout at 0x020C = 8'h03.
4. DONE, then M1 at 0x03C3 → active=0, state READY; a second M1 at 0x0347 restarts from tape_rd_addr=0.
5. Mid-COPY, dl_active rises → no ram_we afterwards, active=0, tape_ready=0.
6. TAPE_LOAD_LED_EN defined, tape_len=600 → led toggles after bytes 256 and 512, led=1 in DONE.
